// File: rtl/gamma_share_sched.sv
// gamma_share_sched: gamma-cycle scheduler for the shared memory group.
// Runs the free-running gamma phase counter, emits the grst boundary pulse,
// and hands the memory group to one requester per gamma cycle (round-robin).
// A mem_rst pulse goes out on each boundary where the owner changes.
// Optional feature macro: GAMMA_SHARE_SCHED_HOLD_EN. When it is defined, the
// current owner keeps the group for as long as it holds req.

// Per-requester done decode: pulse in the last phase of an owned cycle.
module gamma_share_lane (
  input  logic gnt_bit,
  input  logic last_phase,
  output logic done
);
  assign done = gnt_bit & last_phase;
endmodule

module gamma_share_sched #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NREQ              = 4
) (
  input  logic                                 aclk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [NREQ-1:0]                      req,
  output logic                                 grst,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] phase,
  output logic [NREQ-1:0]                      gnt,
  output logic                                 gnt_valid,
  output logic                                 mem_rst,
  output logic [NREQ-1:0]                      done
);
  localparam int PW   = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0]   LAST  = PW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [PTRW:0]   NREQ_W = (PTRW+1)'(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state;
  logic [PTRW-1:0]   ptr;       // last non-zero owner
  logic              own_vld;   // ptr names a real owner since reset/IDLE
  logic              wrap;
  logic              boundary;  // this edge enters phase 0 of a running cycle
  logic              last_ph;
  logic [NREQ-1:0]   arb_gnt;
  logic [PTRW-1:0]   arb_idx;
  logic [PTRW-1:0]   arb_try;
  logic [PTRW:0]     arb_sum;
  logic              arb_mrst;

  assign wrap      = (state != S_IDLE) && (phase == LAST);
  assign boundary  = enable && ((state == S_IDLE) || wrap);
  assign last_ph   = (state != S_IDLE) && (phase == LAST);
  assign grst      = (state != S_IDLE) && (phase == '0);
  assign gnt_valid = |gnt;

  // Round-robin pick over req, searching from ptr+1 and ending at ptr itself.
  always_comb begin
    arb_gnt = '0;
    arb_idx = ptr;
    arb_try = '0;
    arb_sum = '0;
    for (int k = 1; k <= NREQ; k++) begin
      arb_sum = {1'b0, ptr} + (PTRW+1)'(k);
      if (arb_sum >= NREQ_W) arb_sum = arb_sum - NREQ_W;
      arb_try = arb_sum[PTRW-1:0];
      if ((arb_gnt == '0) && req[arb_try]) begin
        arb_gnt[arb_try] = 1'b1;
        arb_idx          = arb_try;
      end
    end
`ifdef GAMMA_SHARE_SCHED_HOLD_EN
    // Sitting owner with req still high keeps the group.
    if (gnt[ptr] && req[ptr]) begin
      arb_gnt      = '0;
      arb_gnt[ptr] = 1'b1;
      arb_idx      = ptr;
    end
`endif
    // Clear the group only when a real owner change happens.
    arb_mrst = (|arb_gnt) && (!own_vld || (arb_idx != ptr));
  end

  // Scheduler FSM: phase counter, grant register, owner pointer, mem_rst.
  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      phase   <= '0;
      gnt     <= '0;
      mem_rst <= 1'b0;
      ptr     <= PTRW'(NREQ - 1);
      own_vld <= 1'b0;
    end else begin
      mem_rst <= 1'b0;
      if (boundary) begin
        gnt     <= arb_gnt;
        mem_rst <= arb_mrst;
        if (|arb_gnt) begin
          ptr     <= arb_idx;
          own_vld <= 1'b1;
        end
      end
      unique case (state)
        S_IDLE: begin
          phase <= '0;
          if (enable) state <= S_RUN;
        end
        S_RUN, S_DRAIN: begin
          if (wrap) begin
            phase <= '0;
            if (enable) begin
              state <= S_RUN;
            end else begin
              state   <= S_IDLE;
              gnt     <= '0;
              own_vld <= 1'b0;
            end
          end else begin
            phase <= phase + 1'b1;
            state <= enable ? S_RUN : S_DRAIN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    gamma_share_lane u_lane (
      .gnt_bit    (gnt[i]),
      .last_phase (last_ph),
      .done       (done[i])
    );
  end

endmodule

// File: tb/tb_gamma_share_sched.sv
// tb_gamma_share_sched: directed bench with a boundary scoreboard.
// Stimulus pushes the expected {gnt, mem_rst} of each upcoming gamma cycle;
// the monitor pops one entry per grst and checks done at the last phase.
module tb_gamma_share_sched;
  localparam int GCW  = 16;
  localparam int NREQ = 4;

  logic            aclk;
  logic            rst;
  logic            enable;
  logic [NREQ-1:0] req;
  logic            grst;
  logic [3:0]      phase;
  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  logic            mem_rst;
  logic [NREQ-1:0] done;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic            mrst;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic have_cur;
  int   vectors;
  int   miscompares;

  gamma_share_sched #(.GAMMA_CYCLE_WIDTH(GCW), .NREQ(NREQ)) dut (
    .aclk      (aclk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .grst      (grst),
    .phase     (phase),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .mem_rst   (mem_rst),
    .done      (done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endfunction

  function automatic void push(logic [NREQ-1:0] g, logic m);
    exp_t e;
    e.gnt  = g;
    e.mrst = m;
    exp_q.push_back(e);
  endfunction

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while ((int'(phase) != p) && (n < 64));
    if (int'(phase) != p) chk("wait_phase_timeout", 32'(phase), 32'(p));
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_grst"},  32'(grst),      32'd0);
    chk({nm, "_phase"}, 32'(phase),     32'd0);
    chk({nm, "_gnt"},   32'(gnt),       32'd0);
    chk({nm, "_gval"},  32'(gnt_valid), 32'd0);
    chk({nm, "_mrst"},  32'(mem_rst),   32'd0);
    chk({nm, "_done"},  32'(done),      32'd0);
  endtask

  // Monitor: one scoreboard entry per gamma boundary, done checked at phase 15.
  always @(negedge aclk) begin
    if (rst) begin
      if (grst) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grst", 32'(gnt), 32'hFFFF_FFFF);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          chk("bnd_gnt",  32'(gnt),       32'(cur.gnt));
          chk("bnd_gval", 32'(gnt_valid), 32'(|cur.gnt));
          chk("bnd_mrst", 32'(mem_rst),   32'(cur.mrst));
        end
      end else if (mem_rst) begin
        chk("mrst_outside_grst", 32'(mem_rst), 32'd0);
      end
      if (have_cur && (phase == 4'(GCW - 1))) begin
        chk("last_gnt",  32'(gnt),  32'(cur.gnt));
        chk("last_done", 32'(done), 32'(cur.gnt));
        have_cur = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, %0d entries pending", exp_q.size());
    $fatal(1);
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    have_cur = 1'b0;
    rst = 1'b0;
    enable = 1'b0;
    req = '0;
    repeat (2) @(negedge aclk);
    chk_idle("reset");
    rst = 1'b1;
    @(negedge aclk);
    chk_idle("idle_after_reset");

    // T1: running with no requests
    push(4'b0000, 1'b0);
    push(4'b0000, 1'b0);
    push(4'b0000, 1'b0);
    enable = 1'b1;
    @(negedge aclk);
    chk("t1_grst_latency", 32'(grst), 32'd1);
    repeat (3) wait_phase(15);

    // T2: all four requesting from boundary 4
    req = 4'b1111;
`ifdef GAMMA_SHARE_SCHED_HOLD_EN
    push(4'b0001, 1'b1);
    push(4'b0001, 1'b0);
    push(4'b0001, 1'b0);
    push(4'b0001, 1'b0);
    push(4'b0001, 1'b0);
`else
    push(4'b0001, 1'b1);
    push(4'b0010, 1'b1);
    push(4'b0100, 1'b1);
    push(4'b1000, 1'b1);
    push(4'b0001, 1'b1);
`endif
    repeat (5) wait_phase(15);

    // T3: req 0101, then drop req[0] mid-cycle
    req = 4'b0101;
`ifdef GAMMA_SHARE_SCHED_HOLD_EN
    push(4'b0001, 1'b0);
    push(4'b0001, 1'b0);
`else
    push(4'b0100, 1'b1);
    push(4'b0001, 1'b1);
`endif
    push(4'b0100, 1'b1);
    wait_phase(15);
    wait_phase(7);
    req = 4'b0100;

    // T4: enable low mid-cycle drains to IDLE
    wait_phase(5);
    enable = 1'b0;
    wait_phase(15);
    @(negedge aclk);
    chk_idle("t4_idle");
    @(negedge aclk);
    chk("t4_idle_phase", 32'(phase), 32'd0);
    push(4'b0100, 1'b1);
    enable = 1'b1;
    @(negedge aclk);
    chk("t4_grst_latency", 32'(grst), 32'd1);

    // T5: owner 3, then async reset at phase 9
    wait_phase(15);
    req = 4'b1000;
    push(4'b1000, 1'b1);
    wait_phase(9);
    chk("t5_owner_pre_rst", 32'(gnt), 32'b1000);
    rst = 1'b0;
    #1;
    chk_idle("t5_async_rst");
    @(negedge aclk);
    push(4'b1000, 1'b1);
    rst = 1'b1;

    // T6: short req[1] pulse between boundaries is never granted
    wait_phase(15);
    req = 4'b0000;
    push(4'b0000, 1'b0);
    push(4'b0000, 1'b0);
    wait_phase(3);
    req = 4'b0010;
    wait_phase(7);
    req = 4'b0000;
    wait_phase(15);
    wait_phase(15);
    enable = 1'b0;
    repeat (3) @(negedge aclk);
    chk_idle("end_idle");
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
